serial_frame_tx: RTL and testbench

Serial frame transmitter: accepts a parallel word over a valid/ready handshake and emits it one bit per clock on a single serial line, preceded by the 4-bit preamble 1011. It is the transmit end of the 1011-framed serial link; its output feeds the serial input of the downstream 1011 detector/receiver. Between frames the line idles low for a programmable number of gap cycles.

---
 rtl/serial_frame_pkg.sv | 22 ++
 rtl/serial_frame_shreg.sv | 29 ++
 rtl/serial_frame_tx.sv | 146 ++++++++++++++
 tb/tb_serial_frame_tx.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/serial_frame_pkg.sv
// Shared constants for the 1011-framed serial link: state encoding and preamble.
// Used by both the transmitter and the receiver end of the link.
package serial_frame_pkg;

   typedef enum logic [4:0] {
      ST_IDLE = 5'b00001,
      ST_PRE  = 5'b00010,
      ST_DATA = 5'b00100,
      ST_PAR  = 5'b01000,
      ST_GAP  = 5'b10000
   } state_e;

   localparam logic [3:0] PREAMBLE = 4'b1011;
   localparam int         PRE_LEN  = 4;

   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/serial_frame_shreg.sv
// Loadable MSB-first shift register; zeros enter at the LSB on each shift.
module serial_frame_shreg #(
   parameter int W = 8
) (
   input  logic         clk_i,
   input  logic         rst_n_i,
   input  logic         load_i,
   input  logic         shift_i,
   input  logic [W-1:0] din_i,
   output logic         sout_o
);

   logic [W-1:0] sr_q, sr_d;

   always_comb begin
      sr_d = sr_q;
      if (load_i)       sr_d = din_i;
      else if (shift_i) sr_d = sr_q << 1;
   end

   // NOTE: a shift register is ordinary state, not a memory array, so it takes the reset like any flop.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) sr_q <= '0;
      else          sr_q <= sr_d;
   end

   assign sout_o = sr_q[W-1];

endmodule

// File: rtl/serial_frame_tx.sv
// Serial frame transmitter: preamble 1011, DW payload bits MSB-first, optional
// even-parity bit (SERIAL_FRAME_TX_PARITY_EN), then GAP idle-low cycles.
module serial_frame_tx
   import serial_frame_pkg::*;
#(
   parameter int DW  = 8,
   parameter int GAP = 2
) (
   input  logic          clk_i,
   input  logic          rst_n_i,
   input  logic [DW-1:0] data_i,
   input  logic          valid_i,
   output logic          ready_o,
   output logic          seq_o,
   output logic          busy_o,
   output logic          done_o
);

   localparam int             CW        = $clog2(max3(DW, GAP, PRE_LEN) + 1);
   localparam logic [CW-1:0]  PRE_LOAD  = CW'(PRE_LEN - 1);
   localparam logic [CW-1:0]  DATA_LOAD = CW'(DW - 1);
   localparam logic [CW-1:0]  GAP_LOAD  = CW'((GAP > 0) ? GAP - 1 : 0);
   localparam state_e         END_ST    = (GAP > 0) ? ST_GAP : ST_IDLE;

   state_e        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          seq_q, seq_d;
   logic          last_q, last_d;
   logic          done_q, done_d;
   logic          pre_shift, dat_shift, pre_sout, dat_sout, hs;

`ifdef SERIAL_FRAME_TX_PARITY_EN
   logic          par_q, par_d;
`endif

   assign ready_o = (state_q == ST_IDLE);
   assign busy_o  = !ready_o;
   assign hs      = valid_i && ready_o;
   assign seq_o   = seq_q;
   assign done_o  = done_q;

   serial_frame_shreg #(.W(PRE_LEN)) u_pre (
      .clk_i   (clk_i),
      .rst_n_i (rst_n_i),
      .load_i  (hs),
      .shift_i (pre_shift),
      .din_i   (PREAMBLE),
      .sout_o  (pre_sout)
   );

   serial_frame_shreg #(.W(DW)) u_dat (
      .clk_i   (clk_i),
      .rst_n_i (rst_n_i),
      .load_i  (hs),
      .shift_i (dat_shift),
      .din_i   (data_i),
      .sout_o  (dat_sout)
   );

   // NOTE: every signal written here gets a default first so no path can infer a latch.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      seq_d     = 1'b0;
      last_d    = 1'b0;
      done_d    = last_q;
      pre_shift = 1'b0;
      dat_shift = 1'b0;
`ifdef SERIAL_FRAME_TX_PARITY_EN
      par_d     = hs ? ^data_i : par_q;
`endif
      case (state_q)
         ST_IDLE: if (valid_i) begin
            state_d = ST_PRE;
            cnt_d   = PRE_LOAD;
         end
         ST_PRE: begin
            seq_d     = pre_sout;
            pre_shift = 1'b1;
            if (cnt_q == '0) begin
               state_d = ST_DATA;
               cnt_d   = DATA_LOAD;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         ST_DATA: begin
            seq_d     = dat_sout;
            dat_shift = 1'b1;
            if (cnt_q == '0) begin
`ifdef SERIAL_FRAME_TX_PARITY_EN
               state_d = ST_PAR;
               cnt_d   = '0;
`else
               state_d = END_ST;
               cnt_d   = GAP_LOAD;
               last_d  = 1'b1;
`endif
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
`ifdef SERIAL_FRAME_TX_PARITY_EN
         ST_PAR: begin
            seq_d   = par_q;
            state_d = END_ST;
            cnt_d   = GAP_LOAD;
            last_d  = 1'b1;
         end
`endif
         ST_GAP: begin
            if (cnt_q == '0) state_d = ST_IDLE;
            else             cnt_d   = cnt_q - 1'b1;
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   // seq and done lag the state by one cycle, so the last-bit marker is piped once more for done.
   // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         seq_q   <= 1'b0;
         last_q  <= 1'b0;
         done_q  <= 1'b0;
`ifdef SERIAL_FRAME_TX_PARITY_EN
         par_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         seq_q   <= seq_d;
         last_q  <= last_d;
         done_q  <= done_d;
`ifdef SERIAL_FRAME_TX_PARITY_EN
         par_q   <= par_d;
`endif
      end
   end

endmodule

// File: tb/tb_serial_frame_tx.sv
// Bench for serial_frame_tx: two instances (GAP=2 and GAP=0) share inputs and are
// compared every cycle against a frame-timeline reference model.
module tb_serial_frame_tx;

   localparam int DW    = 8;
   localparam int DEPTH = 8192;
`ifdef SERIAL_FRAME_TX_PARITY_EN
   localparam int FL = 4 + DW + 1;
   localparam logic [FL-1:0]     EXP_A5    = 13'b1011_1010_0101_0;
   localparam logic [FL-1:0]     EXP_07    = 13'b1011_0000_0111_1;
   localparam logic [2*FL:0]     EXP_FF_00 = {13'b1011_1111_1111_0, 1'b0, 13'b1011_0000_0000_0};
`else
   localparam int FL = 4 + DW;
   localparam logic [FL-1:0]     EXP_A5    = 12'b1011_1010_0101;
   localparam logic [FL-1:0]     EXP_07    = 12'b1011_0000_0111;
   localparam logic [2*FL:0]     EXP_FF_00 = {12'b1011_1111_1111, 1'b0, 12'b1011_0000_0000};
`endif

   logic          clk = 1'b0;
   logic          rst_n;
   logic [DW-1:0] data;
   logic          valid;
   logic          seq_w   [2];
   logic          ready_w [2];
   logic          busy_w  [2];
   logic          done_w  [2];

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;
   bit mon_en  = 1'b0;

   bit exp_seq  [2][DEPTH];
   bit exp_busy [2][DEPTH];
   bit exp_done [2][DEPTH];
   int free_at  [2] = '{-1, -1};

   always #5 clk = ~clk;

   serial_frame_tx #(.DW(DW), .GAP(2)) u_dut0 (
      .clk_i(clk), .rst_n_i(rst_n), .data_i(data), .valid_i(valid),
      .ready_o(ready_w[0]), .seq_o(seq_w[0]), .busy_o(busy_w[0]), .done_o(done_w[0])
   );

   serial_frame_tx #(.DW(DW), .GAP(0)) u_dut1 (
      .clk_i(clk), .rst_n_i(rst_n), .data_i(data), .valid_i(valid),
      .ready_o(ready_w[1]), .seq_o(seq_w[1]), .busy_o(busy_w[1]), .done_o(done_w[1])
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   function automatic int gap_of(input int u);
      return (u == 0) ? 2 : 0;
   endfunction

   function automatic logic [FL-1:0] frame_bits(input logic [DW-1:0] w);
`ifdef SERIAL_FRAME_TX_PARITY_EN
      return {4'b1011, w, ^w};
`else
      return {4'b1011, w};
`endif
   endfunction

   // Reference model: an accepted word at edge k occupies the line on edges k+1..k+FL,
   // done follows one cycle later, and the block is busy until edge k+FL+GAP.
   always @(posedge clk) begin
      cyc++;
      if (rst_n) begin
         for (int u = 0; u < 2; u++) begin
            if (valid && cyc > free_at[u] && cyc + FL + 4 < DEPTH) begin
               logic [FL-1:0] fr;
               fr = frame_bits(data);
               for (int i = 0; i < FL; i++) exp_seq[u][cyc + 1 + i] = fr[FL - 1 - i];
               exp_done[u][cyc + FL + 1] = 1'b1;
               for (int j = cyc; j < cyc + FL + gap_of(u); j++) exp_busy[u][j] = 1'b1;
               free_at[u] = cyc + FL + gap_of(u);
            end
         end
      end
   end

   always @(negedge clk) begin
      if (rst_n && mon_en) begin
         for (int u = 0; u < 2; u++) begin
            check($sformatf("seq%0d", u),   seq_w[u],   exp_seq[u][cyc]);
            check($sformatf("busy%0d", u),  busy_w[u],  exp_busy[u][cyc]);
            check($sformatf("ready%0d", u), ready_w[u], !exp_busy[u][cyc]);
            check($sformatf("done%0d", u),  done_w[u],  exp_done[u][cyc]);
         end
      end
   end

   task automatic model_reset();
      for (int u = 0; u < 2; u++) begin
         for (int i = cyc; i < DEPTH; i++) begin
            exp_seq[u][i]  = 1'b0;
            exp_busy[u][i] = 1'b0;
            exp_done[u][i] = 1'b0;
         end
         free_at[u] = cyc;
      end
   endtask

   task automatic idle(input int n);
      valid = 1'b0;
      repeat (n) @(negedge clk);
   endtask

   task automatic send_and_capture(input string tag, input logic [DW-1:0] w, input logic [FL-1:0] exp);
      logic [FL-1:0] cap;
      valid = 1'b1;
      data  = w;
      @(negedge clk);
      valid = 1'b0;
      data  = DW'($urandom);
      for (int i = 0; i < FL; i++) begin
         @(negedge clk);
         cap[FL - 1 - i] = seq_w[0];
      end
      check(tag, cap, exp);
      @(negedge clk);
      check({tag, "_done"}, done_w[0], 1'b1);
      check({tag, "_gap0"}, seq_w[0], 1'b0);
      @(negedge clk);
      check({tag, "_gap1"}, seq_w[0], 1'b0);
      check({tag, "_ready"}, ready_w[0], 1'b1);
   endtask

   initial begin
      #500000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [2*FL:0] cap2;
      rst_n = 1'b0;
      valid = 1'b1;
      data  = 8'hA5;
      repeat (3) begin
         @(negedge clk);
         for (int u = 0; u < 2; u++) begin
            check($sformatf("rst_seq%0d", u),   seq_w[u],   1'b0);
            check($sformatf("rst_ready%0d", u), ready_w[u], 1'b1);
            check($sformatf("rst_busy%0d", u),  busy_w[u],  1'b0);
            check($sformatf("rst_done%0d", u),  done_w[u],  1'b0);
         end
      end
      valid = 1'b0;
      rst_n = 1'b1;
      mon_en = 1'b1;
      idle(3);

      send_and_capture("frame_a5", 8'hA5, EXP_A5);
      idle(20);
      send_and_capture("frame_07", 8'h07, EXP_07);
      idle(20);

      // GAP=0 instance with valid held high: FF then 00, one idle-low cycle between.
      valid = 1'b1;
      data  = 8'hFF;
      @(negedge clk);
      data  = 8'h00;
      for (int i = 0; i <= 2 * FL; i++) begin
         @(negedge clk);
         cap2[2 * FL - i] = seq_w[1];
         if (i == FL) check("b2b_done", done_w[1], 1'b1);
         if (i == FL + 2) valid = 1'b0;
      end
      check("b2b_line", cap2, EXP_FF_00);
      idle(25);

      // Random traffic: valid toggles freely, including while busy.
      for (int i = 0; i < 1500; i++) begin
         valid = ($urandom_range(0, 3) != 0);
         data  = DW'($urandom);
         @(negedge clk);
      end
      idle(25);

      // Abort mid-payload after the third data bit is on the line.
      valid = 1'b1;
      data  = DW'($urandom);
      @(negedge clk);
      valid = 1'b0;
      repeat (7) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      model_reset();
      for (int u = 0; u < 2; u++) begin
         check($sformatf("abort_seq%0d", u),   seq_w[u],   1'b0);
         check($sformatf("abort_ready%0d", u), ready_w[u], 1'b1);
         check($sformatf("abort_busy%0d", u),  busy_w[u],  1'b0);
         check($sformatf("abort_done%0d", u),  done_w[u],  1'b0);
      end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      idle(30);
      send_and_capture("after_rst", 8'hA5, EXP_A5);
      idle(20);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
